// File: rtl/dtw_core_ref_multi_if.sv
// Source-FIFO link of the multi-bank DTW reference store.
// master: the core (pops/clears); slave: the FIFO (head word, empty flag).
interface dtw_core_ref_multi_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  src_fifo_clear_out;
   logic                  src_fifo_rden_out;
   logic                  src_fifo_empty_in;
   logic [DATA_WIDTH-1:0] src_fifo_data_in;

   modport master (
      output src_fifo_clear_out,
      output src_fifo_rden_out,
      input  src_fifo_empty_in,
      input  src_fifo_data_in
   );

   modport slave (
      input  src_fifo_clear_out,
      input  src_fifo_rden_out,
      output src_fifo_empty_in,
      output src_fifo_data_in
   );
endinterface

// File: rtl/dtw_core_ref_multi.sv
// Multi-bank DTW reference store: NUM_BANKS memories loaded from one FIFO.
// Ports: clk_in/rstn_in (async low), rs_in/op_mode_in/bank_sel_in/ref_len_in
//  control, busy/done/err status, src_if FIFO link (master), per-bank
//  ref_addr_in/ref_data_out read ports, dbg_* observation.
// Option: define REF_CHECKSUM_EN to add ref_csum_out (sum of loaded words).
module dtw_core_ref_multi #(
   parameter int DATA_WIDTH       = 16,
   parameter int ADDR_WIDTH       = 32,
   parameter int REFMEM_PTR_WIDTH = 12,
   parameter int NUM_BANKS        = 4,
   parameter int BANK_SEL_W       = 2
) (
   input  logic                                  clk_in,
   input  logic                                  rstn_in,
   input  logic                                  rs_in,
   input  logic                                  op_mode_in,
   input  logic [BANK_SEL_W-1:0]                 bank_sel_in,
   input  logic [ADDR_WIDTH-1:0]                 ref_len_in,
   output logic                                  busy_out,
   output logic [NUM_BANKS-1:0]                  ref_load_done_out,
   output logic                                  load_err_out,
   dtw_core_ref_multi_if.master                  src_if,
   input  logic [NUM_BANKS*REFMEM_PTR_WIDTH-1:0] ref_addr_in,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]       ref_data_out,
   output logic [1:0]                            dbg_state,
   output logic [31:0]                           dbg_addr_ref,
   output logic                                  dbg_wren_ref
`ifdef REF_CHECKSUM_EN
   ,
   output logic [31:0]                           ref_csum_out
`endif
);
   localparam int PW    = REFMEM_PTR_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int DEPTH = 1 << PW;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_READ = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [BANK_SEL_W-1:0] bank_q, bank_d;
   logic [PW:0]           len_q, len_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [NUM_BANKS-1:0]  done_q, done_d;
   logic                  err_q, err_d;
`ifdef REF_CHECKSUM_EN
   logic [31:0]           csum_q, csum_d;
`endif

   logic [DW-1:0]           mem_q [NUM_BANKS][DEPTH];
   logic [NUM_BANKS*DW-1:0] rd_data_q;

   logic in_load, pop, last, req_bad;

   assign in_load = (state_q == S_LOAD);
   // len_q is one bit wider than wr_ptr so len == DEPTH is representable
   assign pop  = in_load & ~src_if.src_fifo_empty_in
               & ({1'b0, wr_ptr_q} < len_q) & rs_in;
   assign last = ({1'b0, wr_ptr_q} == (len_q - 1'b1));

   assign req_bad = (ref_len_in == '0)
                  | (ref_len_in > ADDR_WIDTH'(DEPTH))
                  | (32'(bank_sel_in) >= NUM_BANKS);

   always_comb begin
      state_d  = state_q;
      bank_d   = bank_q;
      len_d    = len_q;
      wr_ptr_d = wr_ptr_q;
      done_d   = done_q;
      err_d    = err_q;
`ifdef REF_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (rs_in) begin
               if (!op_mode_in) begin
                  state_d = S_READ;
               end else if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  bank_d              = bank_sel_in;
                  len_d               = ref_len_in[PW:0];
                  wr_ptr_d            = '0;
                  err_d               = 1'b0;
                  done_d[bank_sel_in] = 1'b0;
`ifdef REF_CHECKSUM_EN
                  csum_d              = '0;
`endif
                  state_d             = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (!rs_in) begin
               state_d = S_IDLE;
            end else if (pop) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef REF_CHECKSUM_EN
               csum_d   = csum_q + 32'(src_if.src_fifo_data_in);
`endif
               if (last) begin
                  done_d[bank_q] = 1'b1;
                  state_d        = S_IDLE;
               end
            end
         end
         S_READ: begin
            if (!(rs_in && !op_mode_in)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q  <= S_IDLE;
         bank_q   <= '0;
         len_q    <= '0;
         wr_ptr_q <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
`ifdef REF_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         len_q    <= len_d;
         wr_ptr_q <= wr_ptr_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef REF_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   // Storage is not reset; validity is tracked by the done flags.
   always_ff @(posedge clk_in) begin
      if (pop) mem_q[bank_q][wr_ptr_q] <= src_if.src_fifo_data_in;
   end

   // Non-blocking read of the same array gives read-before-write.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         rd_data_q <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            rd_data_q[b*DW +: DW] <= mem_q[b][ref_addr_in[b*PW +: PW]];
         end
      end
   end

   assign busy_out                  = (state_q == S_LOAD) | (state_q == S_READ);
   assign src_if.src_fifo_clear_out = ~busy_out;
   assign src_if.src_fifo_rden_out  = pop;
   assign ref_load_done_out         = done_q;
   assign load_err_out              = err_q;
   assign ref_data_out              = rd_data_q;
   assign dbg_state                 = state_q;
   assign dbg_addr_ref              = 32'(wr_ptr_q);
   assign dbg_wren_ref              = pop;
`ifdef REF_CHECKSUM_EN
   assign ref_csum_out              = csum_q;
`endif
endmodule
